// File: rtl/bram_port_pkg.sv
// Shared types and constants for the block-RAM port initiator.
package bram_port_pkg;

  localparam int unsigned RSP_DATA_WIDTH   = 18;
  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  typedef struct packed {
    logic [RSP_DATA_WIDTH-1:0] rdata;
    logic                      we;
  } bram_rsp_t;

  // Requests that may be outstanding at once: the RAM pipeline plus enough
  // FIFO slack to keep streaming at full rate while the consumer is ready.
  function automatic int unsigned rsp_depth(input int unsigned read_latency);
    return read_latency + 2;
  endfunction

  function automatic bit latency_legal(input int unsigned read_latency);
    return (read_latency >= READ_LATENCY_MIN) && (read_latency <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/bram_port_rsp_fifo.sv
// First-word-fall-through response FIFO; head is zero while empty.
module bram_port_rsp_fifo
  import bram_port_pkg::*;
#(
  parameter int unsigned DEPTH     = 3,
  parameter type         payload_t = bram_rsp_t
) (
  input  logic     clka,
  input  logic     rstb,
  input  logic     push,
  input  payload_t push_data,
  input  logic     pop,
  output payload_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  payload_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop & ~empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage carries no reset; the pointers and count alone decide which
  // entries are live, so clearing them is enough and keeps this a plain RAM.
  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clka) begin
    if (!rstb) begin
      assert (!(push && full))
        else $error("bram_port_rsp_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/bram_port_initiator.sv
// Valid/ready front end for one block-RAM port with credit-based response buffering.
// Optional write acknowledgements: define BRAM_PORT_INITIATOR_WR_ACK_EN.
module bram_port_initiator
  import bram_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_we_o,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_din_o,
  output logic                  bram_regce_o,
  output logic                  bram_rst_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i
);

`ifdef BRAM_PORT_INITIATOR_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  localparam int unsigned D     = rsp_depth(READ_LATENCY);
  localparam int unsigned CNT_W = $clog2(D + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
  } rsp_t;

  logic [CNT_W-1:0]        cnt;
  logic [READ_LATENCY-1:0] tag_v;
  logic [READ_LATENCY-1:0] tag_we;
  logic                    track;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  rsp_t                    fifo_in;
  rsp_t                    fifo_head;

  // NOTE: ready comes only from the registered credit count, so a stalled
  // consumer can never form a combinational loop back into the request side.
  assign req_ready_o  = (cnt < CNT_W'(D));
  assign bram_en_o    = req_valid_i & req_ready_o;
  assign bram_we_o    = bram_en_o & req_we_i;
  assign bram_addr_o  = req_addr_i;
  assign bram_din_o   = req_wdata_i;
  assign bram_regce_o = 1'b1;
  assign bram_rst_o   = rstb;

  assign track = bram_en_o & (~req_we_i | WR_ACK);
  assign pop   = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clka) begin
    if (rstb) begin
      cnt <= '0;
    end else begin
      case ({track, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Tags ride alongside the RAM's fixed read pipeline.
  always_ff @(posedge clka) begin
    if (rstb) begin
      tag_v  <= '0;
      tag_we <= '0;
    end else begin
      tag_v[0]  <= track;
      tag_we[0] <= track & req_we_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_we[i] <= tag_we[i-1];
      end
    end
  end

  assign fifo_in.rdata = tag_we[READ_LATENCY-1] ? '0 : bram_dout_i;
  assign fifo_in.we    = tag_we[READ_LATENCY-1];

  bram_port_rsp_fifo #(
    .DEPTH     (D),
    .payload_t (rsp_t)
  ) u_rsp_fifo (
    .clka      (clka),
    .rstb      (rstb),
    .push      (tag_v[READ_LATENCY-1]),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid_o = ~fifo_empty;
  assign rsp_rdata_o = fifo_head.rdata;
  assign rsp_we_o    = WR_ACK & fifo_head.we;

  // A full FIFO means every credit is parked there, so ready must be low.
  always_ff @(posedge clka) begin
    if (!rstb) begin
      assert (latency_legal(READ_LATENCY))
        else $error("bram_port_initiator: illegal READ_LATENCY %0d", READ_LATENCY);
      assert (!(fifo_full && req_ready_o))
        else $error("bram_port_initiator: credit count out of step with FIFO");
    end
  end

endmodule

// File: tb/tb_bram_port_initiator.sv
// Scoreboard bench: two initiators (READ_LATENCY 1 and 2), each on a behavioural RAM.
module tb_bram_port_initiator;

`ifdef BRAM_PORT_INITIATOR_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [17:0] data;
  } exp_t;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  always #5 clka = ~clka;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [9:0]  req_addr   [2];
  logic [17:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [17:0] rsp_rdata  [2];
  logic        rsp_we     [2];
  logic        bram_en    [2];
  logic        bram_we    [2];
  logic [9:0]  bram_addr  [2];
  logic [17:0] bram_din   [2];
  logic        bram_regce [2];
  logic        bram_rst   [2];
  logic [17:0] bram_dout  [2];

  logic [17:0] shadow [2][1024];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rsp_count = 0;

  function automatic logic [17:0] init_val(input logic [9:0] a);
    return (a == 10'h005) ? 18'h02A5A : {~a[7:0], a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [17:0] mem [1024];
    logic [17:0] q1;
    logic [17:0] q2;

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = init_val(10'(i));
      q1 = '0;
      q2 = '0;
    end

    always @(posedge clka) begin
      if (bram_en[g]) begin
        if (bram_we[g]) mem[bram_addr[g]] <= bram_din[g];
        else            q1 <= mem[bram_addr[g]];
      end
      if (bram_rst[g])        q2 <= '0;
      else if (bram_regce[g]) q2 <= q1;
    end

    assign bram_dout[g] = (g == 0) ? q1 : q2;

    bram_port_initiator #(
      .ADDR_WIDTH   (10),
      .DATA_WIDTH   (18),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clka         (clka),
      .rstb         (rstb),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_we_i     (req_we[g]),
      .req_addr_i   (req_addr[g]),
      .req_wdata_i  (req_wdata[g]),
      .rsp_valid_o  (rsp_valid[g]),
      .rsp_ready_i  (rsp_ready[g]),
      .rsp_rdata_o  (rsp_rdata[g]),
      .rsp_we_o     (rsp_we[g]),
      .bram_en_o    (bram_en[g]),
      .bram_we_o    (bram_we[g]),
      .bram_addr_o  (bram_addr[g]),
      .bram_din_o   (bram_din[g]),
      .bram_regce_o (bram_regce[g]),
      .bram_rst_o   (bram_rst[g]),
      .bram_dout_i  (bram_dout[g])
    );
  end

  // One clock of traffic, entered and left at a falling edge.
  task automatic step(input int d, input logic v, input logic we, input logic [9:0] a,
                      input logic [17:0] wd, input logic rr, output logic acc);
    exp_t e;
    req_valid[d] = v;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    rsp_ready[d] = rr;
    acc = v && (req_ready[d] === 1'b1);
    #1;
    n_checks++;
    if (bram_en[d] !== acc || bram_we[d] !== (acc && we)) begin
      n_errors++;
      $display("FAIL bram_strobe dut%0d: en=%b we=%b expected en=%b we=%b", d, bram_en[d], bram_we[d], acc, acc && we);
    end
    if (acc) begin
      n_checks++;
      if (bram_addr[d] !== a || bram_din[d] !== wd) begin
        n_errors++;
        $display("FAIL bram_passthru dut%0d: addr=%h din=%h expected addr=%h din=%h", d, bram_addr[d], bram_din[d], a, wd);
      end
    end
    if (rsp_valid[d] === 1'b1 && rr) begin
      rsp_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL stale_rsp dut%0d: got we=%b data=%h expected no response", d, rsp_we[d], rsp_rdata[d]);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata[d] !== e.data || rsp_we[d] !== e.we) begin
          n_errors++;
          $display("FAIL rsp_data dut%0d: got we=%b data=%h expected we=%b data=%h", d, rsp_we[d], rsp_rdata[d], e.we, e.data);
        end
      end
    end
    if (acc) begin
      if (we) begin
        shadow[d][a] = wd;
        if (WR_ACK) begin
          e = '{we: 1'b1, data: 18'h0};
          exp_q.push_back(e);
        end
      end else begin
        e = '{we: 1'b0, data: shadow[d][a]};
        exp_q.push_back(e);
      end
    end
    @(posedge clka);
    @(negedge clka);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    logic acc;
    int   cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      step(d, 1'b0, 1'b0, 10'h0, 18'h0, 1'b1, acc);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || rsp_valid[d] !== 1'b0) begin
      n_errors++;
      $display("FAIL drain dut%0d: pending=%0d rsp_valid=%b expected pending=0 rsp_valid=0", d, exp_q.size(), rsp_valid[d]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    repeat (2) @(negedge clka);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 18'h0 || rsp_we[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_outputs dut%0d: ready=%b valid=%b rdata=%h we=%b expected 1 0 0 0", d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_we[d]);
      end
      n_checks++;
      if (bram_rst[d] !== 1'b1 || bram_regce[d] !== 1'b1 || bram_en[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_bram dut%0d: rst=%b regce=%b en=%b expected 1 1 0", d, bram_rst[d], bram_regce[d], bram_en[d]);
      end
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 10'h3FF;
      req_wdata[d] = 18'h3ABCD;
      #1;
      n_checks++;
      if (bram_en[d] !== 1'b1 || bram_we[d] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_follow dut%0d: en=%b we=%b expected 1 1", d, bram_en[d], bram_we[d]);
      end
      shadow[d][10'h3FF] = 18'h3ABCD;
    end
    @(negedge clka);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    rstb = 1'b0;
    @(negedge clka);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (bram_rst[d] !== 1'b0 || req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_release dut%0d: rst=%b ready=%b valid=%b expected 0 1 0", d, bram_rst[d], req_ready[d], rsp_valid[d]);
      end
    end
  endtask

  task automatic test_single_read();
    logic acc;
    rsp_count = 0;
    step(0, 1'b1, 1'b0, 10'h005, 18'h0, 1'b0, acc);
    n_checks++;
    if (acc !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL single_accept: acc=%b valid=%b expected acc=1 valid=0", acc, rsp_valid[0]);
    end
    step(0, 1'b0, 1'b0, 10'h0, 18'h0, 1'b0, acc);
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 18'h02A5A || rsp_we[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL single_latency: valid=%b rdata=%h we=%b ready=%b expected 1 02a5a 0 1", rsp_valid[0], rsp_rdata[0], rsp_we[0], req_ready[0]);
    end
    step(0, 1'b1, 1'b0, 10'h3FF, 18'h0, 1'b1, acc);
    drain(0);
    n_checks++;
    if (rsp_count != 2) begin
      n_errors++;
      $display("FAIL single_count: got %0d responses expected 2", rsp_count);
    end
  endtask

  task automatic test_stream(input int d);
    logic acc;
    int   gaps = 0;
    rsp_count = 0;
    for (int i = 0; i < 16; i++) begin
      step(d, 1'b1, 1'b0, 10'(100 + i * 3), 18'h0, 1'b1, acc);
      if (!acc) gaps++;
    end
    drain(d);
    n_checks++;
    if (gaps != 0 || rsp_count != 16) begin
      n_errors++;
      $display("FAIL stream dut%0d: gaps=%0d responses=%0d expected gaps=0 responses=16", d, gaps, rsp_count);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int   next = 0;
    int   cyc  = 0;
    rsp_count = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, next < 10, 1'b0, 10'(200 + next), 18'h0, 1'b0, acc);
      if (acc) next++;
    end
    n_checks++;
    if (next != 4 || req_ready[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_credit: accepted=%0d ready=%b expected accepted=4 ready=0", next, req_ready[1]);
    end
    step(1, 1'b1, 1'b0, 10'(200 + next), 18'h0, 1'b1, acc);
    if (acc) next++;
    n_checks++;
    if (acc !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_reopen: acc=%b ready=%b expected acc=0 ready=1", acc, req_ready[1]);
    end
    while ((next < 10 || exp_q.size() > 0) && cyc < 60) begin
      step(1, next < 10, 1'b0, 10'(200 + next), 18'h0, 1'b1, acc);
      if (acc) next++;
      cyc++;
    end
    n_checks++;
    if (next != 10 || rsp_count != 10 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_complete: accepted=%0d responses=%0d pending=%0d expected 10 10 0", next, rsp_count, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_write_read();
    logic acc_w;
    logic acc_r;
    rsp_count = 0;
    step(0, 1'b1, 1'b1, 10'h010, 18'h01234, 1'b1, acc_w);
    step(0, 1'b1, 1'b0, 10'h010, 18'h0, 1'b1, acc_r);
    drain(0);
    n_checks++;
    if (acc_w !== 1'b1 || acc_r !== 1'b1 || rsp_count != (WR_ACK ? 2 : 1)) begin
      n_errors++;
      $display("FAIL write_read: acc_w=%b acc_r=%b responses=%0d expected 1 1 %0d", acc_w, acc_r, rsp_count, WR_ACK ? 2 : 1);
    end
  endtask

  task automatic test_reset_inflight();
    logic acc;
    int   accepted = 0;
    rsp_count = 0;
    for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0, 10'(300 + i), 18'h0, 1'b0, acc);
    rstb = 1'b1;
    step(1, 1'b0, 1'b0, 10'h0, 18'h0, 1'b0, acc);
    n_checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 18'h0 || req_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL inflight_reset: valid=%b rdata=%h ready=%b expected 0 0 1", rsp_valid[1], rsp_rdata[1], req_ready[1]);
    end
    exp_q.delete();
    rstb = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 1'b0, 1'b0, 10'h0, 18'h0, 1'b1, acc);
    for (int i = 0; i < 6; i++) begin
      step(1, 1'b1, 1'b0, 10'(310 + i), 18'h0, 1'b0, acc);
      if (acc) accepted++;
    end
    n_checks++;
    if (accepted != 4 || rsp_count != 0) begin
      n_errors++;
      $display("FAIL inflight_credit: accepted=%0d stale=%0d expected accepted=4 stale=0", accepted, rsp_count);
    end
    drain(1);
  endtask

  task automatic test_random();
    logic acc;
    for (int d = 0; d < 2; d++) begin
      rsp_count = 0;
      for (int i = 0; i < 5000; i++) begin
        step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 10'($urandom_range(0, 15)),
             18'($urandom), $urandom_range(0, 3) != 0, acc);
      end
      drain(d);
      n_checks++;
      if (rsp_count < 100) begin
        n_errors++;
        $display("FAIL random_activity dut%0d: responses=%0d expected at least 100", d, rsp_count);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
      for (int i = 0; i < 1024; i++) shadow[d][i] = init_val(10'(i));
    end
    test_reset();
    test_single_read();
    test_stream(0);
    test_stream(1);
    test_backpressure();
    test_write_read();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
